pe_scatter_ctrl: RTL and testbench
==================================

// Module: pe_scatter_ctrl
// PURPOSE
//  Sequencer for the PE-array 1-to-N demux: accepts a valid/ready data stream and scatters
//  consecutive beats to lanes 0..len-1, repeating for a programmed number of rounds.
//  Drives demux sel/en/data plus a one-hot per-lane write strobe; sits between the PE
//  input buffer and the demux feeding the PE lane registers.
// PARAMETERS
//  DATA_WIDTH  8                      beat width, matches demux DATA_WIDTH
//  DATA_DEPTH  33                     number of PE lanes, matches demux DATA_DEPTH
//  SEL_WIDTH   $clog2(DATA_DEPTH)     demux select width
//  RND_WIDTH   8                      width of round counter / cfg_rounds
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  start       in   1           pulse: latch cfg_* and begin a scatter job
//  cfg_len     in   SEL_WIDTH+1 lanes per round, legal 1..DATA_DEPTH
//  cfg_rounds  in   RND_WIDTH   rounds per job, legal >=1
//  abort       in   1           terminate current job
//  in_data     in   DATA_WIDTH  stream beat
//  in_valid    in   1           beat valid
//  in_ready    out  1           controller can accept a beat
//  dmux_data   out  DATA_WIDTH  registered beat to demux data_in
//  dmux_sel    out  SEL_WIDTH   registered lane index to demux sel
//  dmux_en     out  1           registered demux enable
//  lane_we     out  DATA_DEPTH  one-hot lane write strobe, equals (dmux_en << dmux_sel)
//  busy        out  1           job in progress (state RUN)
//  done        out  1           1-cycle pulse: job completed or aborted
//  err         out  1           1-cycle pulse with done: illegal cfg on start
// BEHAVIOUR
//  Reset: state IDLE; in_ready, dmux_en, lane_we, busy, done, err = 0; dmux_data, dmux_sel = 0.
//  FSM (enum in pe_pkg): IDLE -> RUN on start with legal cfg; IDLE -> FIN on start with
//   cfg_len==0, cfg_len>DATA_DEPTH or cfg_rounds==0 (err=1). RUN -> FIN on last beat of last
//   round accepted, or abort. FIN -> IDLE unconditionally (done=1 in FIN only).
//  start outside IDLE is ignored; cfg_* sampled only on accepted start.
//  in_ready = (state==RUN) && !abort (combinational). Beat accepted when in_valid && in_ready.
//  Latency: accepted beat at cycle N -> dmux_en=1, dmux_sel=lane, dmux_data=beat at N+1;
//   dmux_en=0 in any cycle following no accept. No bubbles required: back-to-back accepts give
//   one lane write per cycle.
//  Lane counter: 0..len-1; at len-1 wraps to 0 and round counter increments; job ends when
//   round==rounds-1 and lane==len-1 on accept. Last beat's write (N+1) coincides with FIN/done.
//  abort in RUN: beat offered in that cycle is not accepted; a write already registered from
//   the previous cycle still completes; next cycle FIN (done=1, err=0), counters cleared.
//  abort in IDLE/FIN ignored. rst mid-job: immediate return to reset values, no done pulse.
//  dmux_sel never exceeds len-1 <= DATA_DEPTH-1; sel values >= DATA_DEPTH never driven.
// STRUCTURE
//  pe_pkg: typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_FIN} scatter_state_e;
//   shared lane-count width constant. No sub-module: single always_ff for state/counters/
//   output regs plus always_comb next-state; demux instantiated beside it at PE top level.
// TESTING
//  1 reset: hold rst 2 cycles mid-job (len=4) -> all outputs 0, IDLE, no done, next start works.
//  2 len=4, rounds=2, valid always high, beats 0x10..0x17 -> sel 0,1,2,3,0,1,2,3 one per
//    cycle from cycle after first accept, lane_we one-hot matches, done once with final write.
//  3 len=33, rounds=1, random valid gaps -> 33 writes in order, dmux_en=0 on gap cycles,
//    sel reaches 32 and no higher.
//  4 abort after 2 accepts (len=5) -> beat in abort cycle not accepted, 2 writes total,
//    done=1 err=0 next cycle, busy=0 after.
//  5 start with cfg_len=0, then cfg_len=34, then cfg_rounds=0 -> each: no in_ready, done=err=1
//    one cycle, no dmux_en.
//  6 start pulsed again during RUN with different cfg -> ignored; original job completes unchanged.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE-array scatter path.
package pe_pkg;

   typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_FIN} scatter_state_e;

   localparam int unsigned PE_LANES       = 33;
   // Lane counts run 1..PE_LANES, so one bit wider than a lane index.
   localparam int unsigned PE_LANE_CNT_W  = $clog2(PE_LANES) + 1;

endpackage

// File: rtl/pe_scatter_ctrl.sv
// Scatter sequencer: steers consecutive stream beats to PE lanes 0..len-1
// for a programmed number of rounds, driving the lane demux one beat per cycle.
module pe_scatter_ctrl
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = PE_LANES,
   parameter int SEL_WIDTH  = $clog2(DATA_DEPTH),
   parameter int RND_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SEL_WIDTH:0]    cfg_len,
   input  logic [RND_WIDTH-1:0]  cfg_rounds,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] dmux_data,
   output logic [SEL_WIDTH-1:0]  dmux_sel,
   output logic                  dmux_en,
   output logic [DATA_DEPTH-1:0] lane_we,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   scatter_state_e        state_q, state_d;
   logic [SEL_WIDTH:0]    len_q;
   logic [RND_WIDTH-1:0]  rounds_q, rnd_q;
   logic [SEL_WIDTH-1:0]  lane_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] dmux_data_q;
   logic [SEL_WIDTH-1:0]  dmux_sel_q;
   logic                  dmux_en_q;

   logic accept, lane_last, last_beat, cfg_bad;

   assign accept    = in_valid && in_ready;
   assign lane_last = {1'b0, lane_q} == (len_q - (SEL_WIDTH+1)'(1));
   assign last_beat = lane_last && (rnd_q == (rounds_q - RND_WIDTH'(1)));
   assign cfg_bad   = (cfg_len == '0) || (cfg_len > (SEL_WIDTH+1)'(DATA_DEPTH))
                      || (cfg_rounds == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SC_IDLE;
         len_q       <= '0;
         rounds_q    <= '0;
         rnd_q       <= '0;
         lane_q      <= '0;
         err_q       <= 1'b0;
         dmux_data_q <= '0;
         dmux_sel_q  <= '0;
         dmux_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dmux_en_q <= accept;
         if (accept) begin
            dmux_data_q <= in_data;
            dmux_sel_q  <= lane_q;
         end
         unique case (state_q)
            SC_IDLE: if (start) begin
               len_q    <= cfg_len;
               rounds_q <= cfg_rounds;
               lane_q   <= '0;
               rnd_q    <= '0;
               err_q    <= cfg_bad;
            end
            SC_RUN: if (abort || (accept && last_beat)) begin
               lane_q <= '0;
               rnd_q  <= '0;
            end else if (accept) begin
               if (lane_last) begin
                  lane_q <= '0;
                  rnd_q  <= rnd_q + RND_WIDTH'(1);
               end else begin
                  lane_q <= lane_q + SEL_WIDTH'(1);
               end
            end
            default: err_q <= 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SC_IDLE: if (start) state_d = cfg_bad ? SC_FIN : SC_RUN;
         SC_RUN:  if (abort || (accept && last_beat)) state_d = SC_FIN;
         SC_FIN:  state_d = SC_IDLE;
         default: state_d = SC_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      err  = 1'b0;
      unique case (state_q)
         SC_RUN:  busy = 1'b1;
         SC_FIN: begin
            done = 1'b1;
            err  = err_q;
         end
         default: ;
      endcase
      // abort blocks the beat offered in the same cycle.
      in_ready = busy && !abort;
   end

   assign dmux_data = dmux_data_q;
   assign dmux_sel  = dmux_sel_q;
   assign dmux_en   = dmux_en_q;
   assign lane_we   = dmux_en_q ? (DATA_DEPTH'(1) << dmux_sel_q) : '0;

endmodule

// File: tb/tb_pe_scatter_ctrl.sv
// Self-checking bench for pe_scatter_ctrl: job table plus reset corner case,
// with a job-level model of which beat lands on which lane.
module tb_pe_scatter_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  cfg_len;
   logic [7:0]  cfg_rounds;
   logic        abort;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  dmux_data;
   logic [5:0]  dmux_sel;
   logic        dmux_en;
   logic [32:0] lane_we;
   logic        busy, done, err;

   pe_scatter_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_rounds(cfg_rounds),
      .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .dmux_data(dmux_data), .dmux_sel(dmux_sel), .dmux_en(dmux_en), .lane_we(lane_we),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Job model: a job is len*rounds beats, beat k lands on lane k % len.
   bit m_run = 0, m_fin = 0, m_acc = 0;
   int m_k = 0, m_len = 1, m_total = 0;
   int n_wr, n_done, n_err, max_sel;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic st, input int ln, input int rd, input logic ab,
                       input logic vl, input logic [7:0] dt);
      logic        e_ready, e_en, e_done, e_err;
      int          e_sel;
      logic [7:0]  e_data;
      logic [32:0] e_we;
      start = st; cfg_len = ln[6:0]; cfg_rounds = rd[7:0];
      abort = ab; in_valid = vl; in_data = dt;
      #1;
      e_ready = m_run && !ab;
      chk("in_ready", in_ready, e_ready);
      chk("busy", busy, m_run);
      m_acc = vl && e_ready;
      e_en = m_acc; e_done = 0; e_err = 0; e_sel = 0; e_data = 0;
      if (m_acc) begin
         e_sel = m_k % m_len;
         e_data = dt;
         m_k++;
      end
      if (m_run) begin
         if (ab || (m_acc && m_k == m_total)) begin
            e_done = 1;
            m_run = 0;
         end
      end else if (!m_fin && st) begin
         if (ln == 0 || ln > 33 || rd == 0) begin
            e_done = 1;
            e_err = 1;
         end else begin
            m_run = 1; m_k = 0; m_len = ln; m_total = ln * rd;
         end
      end
      @(negedge clk);
      chk("dmux_en", dmux_en, e_en);
      if (e_en) begin
         chk("dmux_sel", dmux_sel, e_sel);
         chk("dmux_data", dmux_data, e_data);
      end
      e_we = e_en ? (33'd1 << e_sel) : 33'd0;
      chk("lane_we", lane_we, e_we);
      chk("done", done, e_done);
      chk("err", err, e_err);
      n_wr += int'(dmux_en);
      n_done += int'(done);
      n_err += int'(err);
      if (dmux_en && int'(dmux_sel) > max_sel) max_sel = int'(dmux_sel);
      m_fin = e_done;
   endtask

   task automatic run_job(input int ln, input int rd, input int pct, input int ab_after,
                          input int base, input bit restart);
      int cyc = 0, acc_cnt = 0;
      logic vl, ab, st;
      n_wr = 0; n_done = 0; n_err = 0; max_sel = 0;
      step(1'b1, ln, rd, 1'b0, 1'b0, 8'h00);
      while ((m_run || m_fin) && cyc < 3000) begin
         ab = (ab_after >= 0) && (acc_cnt == ab_after);
         vl = ab || ($urandom_range(99) < pct);
         st = restart && (cyc == 2);
         step(st, st ? 7 : ln, st ? 1 : rd, ab, vl,
              (pct == 100) ? 8'(base + acc_cnt) : 8'($urandom));
         if (m_acc) acc_cnt++;
         cyc++;
      end
      chk("job_timeout", cyc >= 3000, 0);
      repeat (2) step(1'b0, ln, rd, 1'b0, 1'b1, 8'hee);
   endtask

   typedef struct {
      int ln, rd, pct, ab_after, base;
      bit restart;
      int exp_wr, exp_dn, exp_er, exp_max;
   } job_t;

   job_t jobs[8];

   initial begin
      jobs[0] = '{4, 2, 100, -1, 8'h10, 0,  8, 1, 0, 3};
      jobs[1] = '{33, 1, 60, -1, 0, 0,     33, 1, 0, 32};
      jobs[2] = '{5, 3, 100, 2, 8'h40, 0,   2, 1, 0, 1};
      jobs[3] = '{0, 1, 100, -1, 0, 0,      0, 1, 1, 0};
      jobs[4] = '{34, 1, 100, -1, 0, 0,     0, 1, 1, 0};
      jobs[5] = '{3, 0, 100, -1, 0, 0,      0, 1, 1, 0};
      jobs[6] = '{4, 3, 70, -1, 0, 1,      12, 1, 0, 3};
      jobs[7] = '{1, 5, 100, -1, 8'h80, 0,  5, 1, 0, 0};

      rst = 1; start = 0; cfg_len = 0; cfg_rounds = 0; abort = 0; in_valid = 0; in_data = 0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {in_ready, dmux_en, busy, done, err}, 0);
      chk("rst_data_sel", {dmux_data, dmux_sel, lane_we}, 0);
      rst = 0;

      foreach (jobs[i]) begin
         run_job(jobs[i].ln, jobs[i].rd, jobs[i].pct, jobs[i].ab_after,
                 jobs[i].base, jobs[i].restart);
         chk($sformatf("job%0d_writes", i), n_wr, jobs[i].exp_wr);
         chk($sformatf("job%0d_done", i), n_done, jobs[i].exp_dn);
         chk($sformatf("job%0d_err", i), n_err, jobs[i].exp_er);
         chk($sformatf("job%0d_maxsel", i), max_sel, jobs[i].exp_max);
      end

      // Reset mid-job: outputs clear at once and no done pulse follows.
      n_wr = 0; n_done = 0; n_err = 0; max_sel = 0;
      step(1'b1, 4, 2, 1'b0, 1'b0, 8'h00);
      repeat (3) step(1'b0, 4, 2, 1'b0, 1'b1, 8'h55);
      rst = 1;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_ctrl", {in_ready, dmux_en, busy, done, err}, 0);
         chk("midrst_data", {dmux_data, dmux_sel, lane_we}, 0);
      end
      rst = 0;
      m_run = 0; m_fin = 0;
      repeat (2) step(1'b0, 4, 2, 1'b0, 1'b1, 8'h00);
      chk("midrst_no_done", n_done, 0);
      run_job(4, 2, 100, -1, 8'h20, 0);
      chk("postrst_writes", n_wr, 8);
      chk("postrst_done", n_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
